// File: rtl/vga_pmod_monitor_pkg.sv
// Shared timing, PMOD bit map and FSM encodings
// for the TinyVGA receive-side monitor.
package vga_pmod_monitor_pkg;

  localparam int VGA_H_VIS   = 640;
  localparam int VGA_H_FP    = 16;
  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_TOTAL = 800;
  localparam int VGA_V_VIS   = 480;
  localparam int VGA_V_FP    = 10;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_TOTAL = 525;

  localparam int HSYNC_BIT = 7;
  localparam int B0_BIT    = 6;
  localparam int G0_BIT    = 5;
  localparam int R0_BIT    = 4;
  localparam int VSYNC_BIT = 3;
  localparam int B1_BIT    = 2;
  localparam int G1_BIT    = 1;
  localparam int R1_BIT    = 0;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_HLOCK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int CW = 10;

  typedef struct packed {
    logic          valid;
    logic [CW-1:0] period;
    logic [CW-1:0] width;
  } meas_t;

  function automatic logic [5:0] pmod_rgb(
    input logic [7:0] b
  );
    return {b[R1_BIT], b[R0_BIT],
            b[G1_BIT], b[G0_BIT],
            b[B1_BIT], b[B0_BIT]};
  endfunction

endpackage

// File: rtl/vga_pmod_monitor_sync_meas.sv
// Sync edge period/width meter. Counts ticks between
// falls and ticks spent low; both saturate at 1023.
module vga_pmod_monitor_sync_meas
  import vga_pmod_monitor_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  tick,
  input  logic  fall,
  input  logic  low,
  output meas_t meas
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] wcnt;
  logic          primed;

  function automatic logic [CW-1:0] sat_inc(
    input logic [CW-1:0] x
  );
    return (x == '1) ? x : x + CW'(1);
  endfunction

  // Report the previous cycle at each fall; the very
  // first fall only arms the meter (partial cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      wcnt   <= '0;
      primed <= 1'b0;
      meas   <= '0;
    end else begin
      meas.valid <= fall & primed;
      if (fall) begin
        meas.period <= cnt;
        meas.width  <= wcnt;
        primed      <= 1'b1;
        cnt         <= tick ? CW'(1) : '0;
        wcnt        <= (tick & low) ? CW'(1) : '0;
      end else begin
        if (tick)
          cnt <= sat_inc(cnt);
        if (tick & low)
          wcnt <= sat_inc(wcnt);
      end
    end
  end

endmodule

// File: rtl/vga_pmod_monitor.sv
// TinyVGA PMOD receive checker: sync lock, timing
// validation, pixel position recovery and frame checksum.
module vga_pmod_monitor
  import vga_pmod_monitor_pkg::*;
#(
  parameter int H_VIS   = VGA_H_VIS,
  parameter int H_FP    = VGA_H_FP,
  parameter int H_SYNC  = VGA_H_SYNC,
  parameter int H_TOTAL = VGA_H_TOTAL,
  parameter int V_VIS   = VGA_V_VIS,
  parameter int V_FP    = VGA_V_FP,
  parameter int V_SYNC  = VGA_V_SYNC,
  parameter int V_TOTAL = VGA_V_TOTAL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  uo_in,
  input  logic        clr_err,
  output logic        locked,
  output logic        err_h,
  output logic        err_v,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  pix_rgb,
  output logic        frame_done,
  output logic [15:0] frame_sum
);

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_LOAD = CW'(H_VIS + H_FP);
  localparam logic [CW-1:0] H_LEN  = CW'(H_TOTAL);
  localparam logic [CW-1:0] H_W    = CW'(H_SYNC);
  localparam logic [CW-1:0] H_END  = CW'(H_VIS);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_LOAD = CW'(V_VIS + V_FP);
  localparam logic [CW-1:0] V_LEN  = CW'(V_TOTAL);
  localparam logic [CW-1:0] V_W    = CW'(V_SYNC);
  localparam logic [CW-1:0] V_END  = CW'(V_VIS);

  logic [7:0]    s1;
  logic [7:0]    s2;
  logic          hs_fall;
  logic          vs_fall;
  logic          vfall_d;
  logic [CW-1:0] h;
  logic [CW-1:0] v;
  meas_t         hmeas;
  meas_t         vmeas;
  logic          h_ok;
  logic          v_ok;
  logic          hgood;
  logic          hbad;
  logic          vgood;
  logic          vbad;
  logic [1:0]    state;
  logic [1:0]    state_n;
  logic          hgood1;
  logic          hgood1_n;
  logic          vseen;
  logic          vseen_n;
  logic          set_h;
  logic          set_v;
  logic          full;
  logic [15:0]   acc;

  assign hs_fall = s2[HSYNC_BIT] & ~s1[HSYNC_BIT];
  assign vs_fall = s2[VSYNC_BIT] & ~s1[VSYNC_BIT];

  vga_pmod_monitor_sync_meas u_hmeas (
    .clk  (clk),
    .rst  (rst),
    .tick (1'b1),
    .fall (hs_fall),
    .low  (~s1[HSYNC_BIT]),
    .meas (hmeas)
  );

  vga_pmod_monitor_sync_meas u_vmeas (
    .clk  (clk),
    .rst  (rst),
    .tick (hs_fall),
    .fall (vs_fall),
    .low  (~s1[VSYNC_BIT]),
    .meas (vmeas)
  );

  assign h_ok  = (hmeas.period == H_LEN) &&
                 (hmeas.width == H_W);
  assign v_ok  = (vmeas.period == V_LEN) &&
                 (vmeas.width == V_W);
  assign hgood = hmeas.valid & h_ok;
  assign hbad  = hmeas.valid & ~h_ok;
  assign vgood = vmeas.valid & v_ok;
  assign vbad  = vmeas.valid & ~v_ok;

  assign locked = (state == ST_LOCKED);

  // Input pipeline and position counters; h/v track
  // the sample held in s2.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      vfall_d <= 1'b0;
      h       <= '0;
      v       <= '0;
    end else begin
      s1      <= uo_in;
      s2      <= s1;
      vfall_d <= vs_fall;
      if (hs_fall)
        h <= H_LOAD;
      else if (h == H_LAST)
        h <= '0;
      else
        h <= h + CW'(1);
      if (vs_fall)
        v <= V_LOAD;
      else if (hs_fall)
        v <= (v == V_LAST) ? '0 : v + CW'(1);
    end
  end

  // Lock FSM next state and error set requests.
  always_comb begin
    state_n  = state;
    hgood1_n = hgood1;
    vseen_n  = vseen;
    set_h    = 1'b0;
    set_v    = 1'b0;
    case (state)
      ST_SEARCH: begin
        if (hbad) begin
          hgood1_n = 1'b0;
        end else if (hgood) begin
          if (hgood1) begin
            state_n  = ST_HLOCK;
            hgood1_n = 1'b0;
            vseen_n  = 1'b0;
          end else begin
            hgood1_n = 1'b1;
          end
        end
      end
      ST_HLOCK: begin
        if (hbad) begin
          state_n  = ST_SEARCH;
          hgood1_n = 1'b0;
        end else if (vfall_d) begin
          if (vseen && vgood)
            state_n = ST_LOCKED;
          vseen_n = 1'b1;
        end
      end
      ST_LOCKED: begin
        set_h = hbad;
        set_v = vbad;
        if (hbad || vbad) begin
          state_n  = ST_SEARCH;
          hgood1_n = 1'b0;
        end
      end
      default: begin
        state_n  = ST_SEARCH;
        hgood1_n = 1'b0;
      end
    endcase
  end

  // FSM state and sticky errors (a set beats a clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_SEARCH;
      hgood1 <= 1'b0;
      vseen  <= 1'b0;
      err_h  <= 1'b0;
      err_v  <= 1'b0;
    end else begin
      state  <= state_n;
      hgood1 <= hgood1_n;
      vseen  <= vseen_n;
      if (set_h)
        err_h <= 1'b1;
      else if (clr_err)
        err_h <= 1'b0;
      if (set_v)
        err_v <= 1'b1;
      else if (clr_err)
        err_v <= 1'b0;
    end
  end

  // Registered pixel outputs, two samples behind uo_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_rgb   <= '0;
    end else begin
      pix_valid <= locked && (h < H_END) && (v < V_END);
      pix_x     <= h;
      pix_y     <= v;
      pix_rgb   <= pmod_rgb(s2);
    end
  end

  // Frame checksum; a frame only reports its sum if
  // lock held from its opening vsync to its closing one.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      full       <= 1'b0;
      frame_done <= 1'b0;
      frame_sum  <= '0;
    end else begin
      frame_done <= vfall_d;
      if (vfall_d) begin
        frame_sum <= (full && state_n == ST_LOCKED) ?
                     acc : '0;
        acc       <= '0;
      end else if (pix_valid) begin
        acc <= acc + {10'd0, pix_rgb};
      end
      if (state_n != ST_LOCKED)
        full <= 1'b0;
      else if (vfall_d)
        full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_pmod_monitor.sv
// Directed bench for vga_pmod_monitor using a
// scaled-down raster so whole frames stay short.
module tb_vga_pmod_monitor;

  localparam int HV  = 16;
  localparam int HFP = 2;
  localparam int HS  = 4;
  localparam int HT  = 24;
  localparam int VV  = 6;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VT  = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  uo_in = 8'hFF;
  logic        clr_err = 1'b0;
  logic        locked;
  logic        err_h;
  logic        err_v;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [5:0]  pix_rgb;
  logic        frame_done;
  logic [15:0] frame_sum;

  vga_pmod_monitor #(
    .H_VIS   (HV),
    .H_FP    (HFP),
    .H_SYNC  (HS),
    .H_TOTAL (HT),
    .V_VIS   (VV),
    .V_FP    (VFP),
    .V_SYNC  (VS),
    .V_TOTAL (VT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uo_in      (uo_in),
    .clr_err    (clr_err),
    .locked     (locked),
    .err_h      (err_h),
    .err_v      (err_v),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_rgb    (pix_rgb),
    .frame_done (frame_done),
    .frame_sum  (frame_sum)
  );

  always #5 clk = ~clk;

  int          n_run = 0;
  int          n_fail = 0;
  int          hx[3];
  int          hy[3];
  logic [5:0]  hr[3];
  logic        chk_pos = 1'b0;
  int          n_done = 0;
  int          done_ref;
  logic [15:0] last_sum = '0;
  longint      cyc = 0;
  longint      last_done_t = 0;
  longint      done_gap = 0;
  logic [15:0] model = '0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // {hsync,B0,G0,R0,vsync,B1,G1,R1}, c = {R1,R0,G1,G0,B1,B0}
  function automatic logic [7:0] pmod(
    input logic       hs,
    input logic       vs,
    input logic [5:0] c
  );
    return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
  endfunction

  task automatic check_idle(input string t);
    check({t, "_locked"}, locked, 0);
    check({t, "_err_h"}, err_h, 0);
    check({t, "_err_v"}, err_v, 0);
    check({t, "_pv"}, pix_valid, 0);
    check({t, "_px"}, pix_x, 0);
    check({t, "_py"}, pix_y, 0);
    check({t, "_rgb"}, pix_rgb, 0);
    check({t, "_done"}, frame_done, 0);
    check({t, "_sum"}, frame_sum, 0);
  endtask

  task automatic put(
    input int         x,
    input int         y,
    input logic [5:0] c
  );
    logic       hs;
    logic       vs;
    logic       vis;
    logic [5:0] cc;
    @(negedge clk);
    clr_err = 1'b0;
    cyc++;
    if (frame_done) begin
      n_done++;
      last_sum = frame_sum;
      done_gap = cyc - last_done_t;
      last_done_t = cyc;
    end
    if (chk_pos && hy[2] == VV - 1) begin
      if (hx[2] == HV - 1) begin
        check("pv_edge", pix_valid, 1);
        check("px_edge", pix_x, HV - 1);
        check("py_edge", pix_y, VV - 1);
        check("rgb_edge", pix_rgb, hr[2]);
      end
      if (hx[2] == HV)
        check("pv_past", pix_valid, 0);
    end
    vis = (x < HV) && (y < VV);
    cc  = vis ? c : 6'h00;
    if (vis)
      model = model + {10'd0, cc};
    hs = !(x >= HV + HFP && x < HV + HFP + HS);
    vs = !(y >= VV + VFP && y < VV + VFP + VS);
    hx[2] = hx[1]; hx[1] = hx[0]; hx[0] = x;
    hy[2] = hy[1]; hy[1] = hy[0]; hy[0] = y;
    hr[2] = hr[1]; hr[1] = hr[0]; hr[0] = cc;
    uo_in = pmod(hs, vs, cc);
  endtask

  task automatic send_line(
    input int         y,
    input int         x0,
    input int         len,
    input bit         pat,
    input logic [5:0] c
  );
    for (int x = x0; x < len; x++)
      put(x, y, pat ? 6'(x * 3 + y) : c);
  endtask

  task automatic send_frame(
    input int         nlines,
    input int         bad_y,
    input bit         pat,
    input logic [5:0] c
  );
    model = '0;
    for (int y = 0; y < nlines; y++)
      send_line(y, 0, (y == bad_y) ? HT + 1 : HT, pat, c);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle("rst0");
    rst = 1'b0;

    send_frame(VT, -1, 1'b0, 6'h30);
    check("f1_locked", locked, 0);
    check("f1_done", n_done, 1);
    check("f1_err_h", err_h, 0);

    send_frame(VT, -1, 1'b0, 6'h30);
    check("f2_locked", locked, 1);
    check("f2_err", {err_h, err_v}, 0);
    check("f2_sum", last_sum, 16'h0000);

    send_frame(VT, -1, 1'b0, 6'h30);
    check("f3_sum_red", last_sum, 16'h1200);
    check("f3_done", n_done, 3);

    send_frame(VT, -1, 1'b0, 6'h01);
    check("f4_sum_b", last_sum, 16'h0060);
    check("f4_gap", 32'(done_gap), HT * VT);

    chk_pos = 1'b1;
    send_frame(VT, -1, 1'b1, 6'h00);
    chk_pos = 1'b0;
    check("f5_sum_pat", last_sum, model);

    send_frame(VT, 2, 1'b0, 6'h30);
    check("f6_err_h", err_h, 1);
    check("f6_locked", locked, 0);
    check("f6_err_v", err_v, 0);
    check("f6_sum", last_sum, 16'h0000);

    send_frame(VT, -1, 1'b0, 6'h30);
    check("f7_relock", locked, 1);
    check("f7_sticky", err_h, 1);

    clr_err = 1'b1;
    send_frame(VT, -1, 1'b0, 6'h30);
    check("f8_clr", err_h, 0);
    check("f8_sum", last_sum, 16'h1200);

    send_frame(VT + 1, -1, 1'b0, 6'h30);
    check("f9_sum", last_sum, 16'h1200);

    send_frame(VT, -1, 1'b0, 6'h30);
    check("f10_err_v", err_v, 1);
    check("f10_locked", locked, 0);
    check("f10_err_h", err_h, 0);
    check("f10_sum", last_sum, 16'h0000);

    model = '0;
    for (int y = 0; y < 3; y++)
      send_line(y, 0, HT, 1'b0, 6'h15);
    send_line(3, 0, 10, 1'b0, 6'h15);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("rst1");
    rst = 1'b0;
    done_ref = n_done;
    send_line(3, 10, HT, 1'b0, 6'h15);
    for (int y = 4; y < VV + VFP; y++)
      send_line(y, 0, HT, 1'b0, 6'h15);
    check("rst_nodone", n_done, done_ref);
    for (int y = VV + VFP; y < VT; y++)
      send_line(y, 0, HT, 1'b0, 6'h15);
    check("rst_done", n_done, done_ref + 1);
    check("rst_sum", last_sum, 16'h0000);
    check("rst_locked", locked, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
